// File: rtl/hdmi_island_scheduler_if.sv
// Raster-position in / period-decision out bundle for the HDMI period scheduler.
// The dvi_mode signal exists only when HDMI_SCHED_DVI_FALLBACK_EN is defined.
interface hdmi_island_scheduler_if;
  logic [15:0] cx;
  logic [15:0] cy;
`ifdef HDMI_SCHED_DVI_FALLBACK_EN
  logic        dvi_mode;
`endif
  logic [2:0]  mode;
  logic [3:0]  ctl;
  logic        packet_enable;
  logic [4:0]  packet_pixel_counter;
  logic        video_field_end;
  logic        island_overrun;

`ifdef HDMI_SCHED_DVI_FALLBACK_EN
  modport master (
    output cx, cy, dvi_mode,
    input  mode, ctl, packet_enable, packet_pixel_counter, video_field_end, island_overrun
  );
  modport slave (
    input  cx, cy, dvi_mode,
    output mode, ctl, packet_enable, packet_pixel_counter, video_field_end, island_overrun
  );
`else
  modport master (
    output cx, cy,
    input  mode, ctl, packet_enable, packet_pixel_counter, video_field_end, island_overrun
  );
  modport slave (
    input  cx, cy,
    output mode, ctl, packet_enable, packet_pixel_counter, video_field_end, island_overrun
  );
`endif
endinterface

// File: rtl/hdmi_island_scheduler.sv
// HDMI TX period sequencer: control/preamble, video guard/data, data-island guard/packets.
// Optional DVI fallback (dvi_mode input) enabled by defining HDMI_SCHED_DVI_FALLBACK_EN.
module hdmi_island_scheduler #(
  parameter int unsigned FRAME_WIDTH   = 800,
  parameter int unsigned FRAME_HEIGHT  = 525,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned MAX_PACKETS   = 18
) (
  input  logic                    clk_pixel,
  input  logic                    reset_n,
  hdmi_island_scheduler_if.slave  sched
);

  localparam int unsigned AVAIL_PACKETS = (FRAME_WIDTH > SCREEN_WIDTH + 38) ?
                                          (FRAME_WIDTH - SCREEN_WIDTH - 38) / 32 : 0;
  localparam int unsigned NUM_PACKETS   = (AVAIL_PACKETS < MAX_PACKETS) ? AVAIL_PACKETS : MAX_PACKETS;
  localparam bit          ISL_EN        = (NUM_PACKETS != 0);
  localparam int unsigned PRE_LEN       = 8;
  localparam int unsigned LEAD_LEN      = 2;
  localparam int unsigned DATA_LEN      = NUM_PACKETS * 32;
  localparam int unsigned ISL_LEN       = PRE_LEN + LEAD_LEN + DATA_LEN + 2;
  localparam int unsigned LAST_PKT_OFF  = ISL_EN ? DATA_LEN - 32 : 0;
  localparam int unsigned ISL_START     = SCREEN_WIDTH + 4;
  localparam int unsigned VPRE_START    = FRAME_WIDTH - 10;
  localparam int unsigned VGUARD_START  = FRAME_WIDTH - 2;

  typedef enum logic [2:0] {
    S_CTRL, S_VIDEO, S_VID_PRE, S_VID_GUARD,
    S_ISL_PRE, S_ISL_LEAD, S_ISL_DATA, S_ISL_TRAIL
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cx_q;
  logic [2:0]  mode_q, mode_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        pe_q, pe_d;
  logic [4:0]  ppc_q, ppc_d;
  logic        vfe_q, vfe_d;
  logic        ovr_q, ovr_d;

  logic [15:0] isl_off;
  logic [15:0] data_off;
  logic        seq;
  logic        next_active;
  logic        in_isl_q;
  logic        hdmi_en;

  assign isl_off     = sched.cx - 16'(ISL_START);
  assign data_off    = isl_off - 16'(PRE_LEN + LEAD_LEN);
  assign seq         = (sched.cx == cx_q + 16'd1) ||
                       ((sched.cx == 16'd0) && (cx_q == 16'(FRAME_WIDTH - 1)));
  assign next_active = (sched.cy == 16'(FRAME_HEIGHT - 1)) || (sched.cy < 16'(SCREEN_HEIGHT - 1));
  assign in_isl_q    = (state_q == S_ISL_PRE) || (state_q == S_ISL_LEAD) ||
                       (state_q == S_ISL_DATA) || (state_q == S_ISL_TRAIL);

`ifdef HDMI_SCHED_DVI_FALLBACK_EN
  // DVI/HDMI choice is latched at the start of each line and held for the rest of it.
  logic dvi_q;
  logic dvi_now;
  assign dvi_now = (sched.cx == 16'd0) ? sched.dvi_mode : dvi_q;
  assign hdmi_en = ~dvi_now;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      dvi_q <= 1'b0;
    end else if (sched.cx == 16'd0) begin
      dvi_q <= sched.dvi_mode;
    end
  end
`else
  assign hdmi_en = 1'b1;
`endif

  // Island states are only reachable from the trigger pixel and survive only on
  // sequential cx, so a jump never produces a partial guard band or stray packet.
  always_comb begin
    state_d = S_CTRL;
    mode_d  = 3'd0;
    ctl_d   = 4'b0000;
    pe_d    = 1'b0;
    ppc_d   = 5'd0;
    vfe_d   = (sched.cx == 16'(SCREEN_WIDTH)) && (sched.cy == 16'(SCREEN_HEIGHT - 1));
    ovr_d   = ovr_q;

    if (hdmi_en && next_active && (sched.cx >= 16'(VPRE_START)) && (sched.cx < 16'(VGUARD_START))) begin
      state_d = S_VID_PRE;
    end else if (hdmi_en && next_active && (sched.cx >= 16'(VGUARD_START)) &&
                 (sched.cx < 16'(FRAME_WIDTH))) begin
      state_d = S_VID_GUARD;
    end else if (hdmi_en && ISL_EN && (isl_off < 16'(ISL_LEN)) &&
                 ((isl_off == 16'd0) || (seq && in_isl_q))) begin
      if (isl_off < 16'(PRE_LEN))                          state_d = S_ISL_PRE;
      else if (isl_off < 16'(PRE_LEN + LEAD_LEN))          state_d = S_ISL_LEAD;
      else if (isl_off < 16'(PRE_LEN + LEAD_LEN + DATA_LEN)) state_d = S_ISL_DATA;
      else                                                 state_d = S_ISL_TRAIL;
    end else if ((sched.cx < 16'(SCREEN_WIDTH)) && (sched.cy < 16'(SCREEN_HEIGHT))) begin
      state_d = S_VIDEO;
    end

    if (((state_d == S_VID_PRE) || (state_d == S_VID_GUARD)) && in_isl_q) begin
      ovr_d = 1'b1;
    end

    case (state_d)
      S_VIDEO:     mode_d = 3'd1;
      S_VID_PRE:   ctl_d  = 4'b0001;
      S_VID_GUARD: mode_d = 3'd2;
      S_ISL_PRE:   ctl_d  = 4'b0101;
      S_ISL_LEAD: begin
        mode_d = 3'd4;
        pe_d   = (isl_off == 16'(PRE_LEN + LEAD_LEN - 1));
      end
      S_ISL_DATA: begin
        mode_d = 3'd3;
        ppc_d  = data_off[4:0];
        pe_d   = (data_off[4:0] == 5'd31) && (data_off < 16'(LAST_PKT_OFF));
      end
      S_ISL_TRAIL: mode_d = 3'd4;
      default:     mode_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CTRL;
      cx_q    <= 16'd0;
      mode_q  <= 3'd0;
      ctl_q   <= 4'b0000;
      pe_q    <= 1'b0;
      ppc_q   <= 5'd0;
      vfe_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= sched.cx;
      mode_q  <= mode_d;
      ctl_q   <= ctl_d;
      pe_q    <= pe_d;
      ppc_q   <= ppc_d;
      vfe_q   <= vfe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sched.mode                 = mode_q;
  assign sched.ctl                  = ctl_q;
  assign sched.packet_enable        = pe_q;
  assign sched.packet_pixel_counter = ppc_q;
  assign sched.video_field_end      = vfe_q;
  assign sched.island_overrun       = ovr_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: default 800x525 instance plus a 700-wide
// instance that has no room for data islands.
module tb_hdmi_island_scheduler;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  hdmi_island_scheduler_if bus();
  hdmi_island_scheduler_if bus7();

  hdmi_island_scheduler u_dut (
    .clk_pixel (clk),
    .reset_n   (reset_n),
    .sched     (bus)
  );

  hdmi_island_scheduler #(.FRAME_WIDTH(700)) u_dut7 (
    .clk_pixel (clk),
    .reset_n   (reset_n),
    .sched     (bus7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one raster position; outputs for it are visible just after the next edge.
  task automatic step(input int x, input int y);
    bus.cx = 16'(x);
    bus.cy = 16'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic step7(input int x, input int y);
    bus7.cx = 16'(x);
    bus7.cy = 16'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int em, ec, ep, eppc;
    int pe_cnt, vfe_cnt, bad_cnt, m698, c690;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.cx  = 16'd0; bus.cy  = 16'd0;
    bus7.cx = 16'd0; bus7.cy = 16'd0;
`ifdef HDMI_SCHED_DVI_FALLBACK_EN
    bus.dvi_mode  = 1'b0;
    bus7.dvi_mode = 1'b0;
`endif
    #1;
    chk("rst_mode", 32'(bus.mode), 0);
    chk("rst_ctl", 32'(bus.ctl), 0);
    chk("rst_pe", 32'(bus.packet_enable), 0);
    chk("rst_ppc", 32'(bus.packet_pixel_counter), 0);
    chk("rst_vfe", 32'(bus.video_field_end), 0);
    chk("rst_ovr", 32'(bus.island_overrun), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Full active line with the default three-packet island
    pe_cnt = 0;
    for (int x = 0; x < 800; x++) begin
      step(x, 10);
      em = 0; ec = 0; ep = 0; eppc = 0;
      if (x < 640) em = 1;
      if (x >= 644 && x <= 651) ec = 5;
      if (x == 652 || x == 653 || x == 750 || x == 751) em = 4;
      if (x >= 654 && x <= 749) begin em = 3; eppc = (x - 654) % 32; end
      if (x >= 790 && x <= 797) ec = 1;
      if (x >= 798) em = 2;
      if (x == 653 || x == 685 || x == 717) ep = 1;
      chk($sformatf("l10_mode@%0d", x), 32'(bus.mode), 32'(em));
      chk($sformatf("l10_ctl@%0d", x), 32'(bus.ctl), 32'(ec));
      chk($sformatf("l10_pe@%0d", x), 32'(bus.packet_enable), 32'(ep));
      chk($sformatf("l10_ppc@%0d", x), 32'(bus.packet_pixel_counter), 32'(eppc));
      chk($sformatf("l10_vfe@%0d", x), 32'(bus.video_field_end), 0);
      pe_cnt += int'(bus.packet_enable);
    end
    chk("l10_pe_count", 32'(pe_cnt), 3);

    // Last active line: field end pulse, no video preamble for the blank line after
    vfe_cnt = 0;
    for (int x = 0; x < 800; x++) begin
      step(x, 479);
      vfe_cnt += int'(bus.video_field_end);
      if (x == 640) chk("l479_vfe", 32'(bus.video_field_end), 1);
      if (x >= 790) begin
        chk($sformatf("l479_mode@%0d", x), 32'(bus.mode), 0);
        chk($sformatf("l479_ctl@%0d", x), 32'(bus.ctl), 0);
      end
    end
    chk("l479_vfe_count", 32'(vfe_cnt), 1);

    // Last frame line: video preamble/guard before line 0
    for (int x = 780; x < 800; x++) begin
      step(x, 524);
      chk($sformatf("l524_ctl@%0d", x), 32'(bus.ctl), (x >= 790 && x <= 797) ? 32'd1 : 32'd0);
      chk($sformatf("l524_mode@%0d", x), 32'(bus.mode), (x >= 798) ? 32'd2 : 32'd0);
    end
    step(0, 0);
    chk("l0_mode@0", 32'(bus.mode), 1);

    // Jump from mid-island into the video preamble trigger
    for (int x = 640; x <= 700; x++) step(x, 20);
    chk("abort_pre_mode", 32'(bus.mode), 3);
    chk("abort_pre_ovr", 32'(bus.island_overrun), 0);
    for (int x = 790; x < 800; x++) begin
      step(x, 20);
      chk($sformatf("abort_ctl@%0d", x), 32'(bus.ctl), (x <= 797) ? 32'd1 : 32'd0);
      chk($sformatf("abort_mode@%0d", x), 32'(bus.mode), (x >= 798) ? 32'd2 : 32'd0);
      chk($sformatf("abort_pe@%0d", x), 32'(bus.packet_enable), 0);
      chk($sformatf("abort_ovr@%0d", x), 32'(bus.island_overrun), 1);
    end

    // Asynchronous reset mid-island
    for (int x = 640; x <= 660; x++) step(x, 30);
    chk("rstmid_before", 32'(bus.mode), 3);
    reset_n = 1'b0;
    #1;
    chk("rstmid_mode", 32'(bus.mode), 0);
    chk("rstmid_ctl", 32'(bus.ctl), 0);
    chk("rstmid_ppc", 32'(bus.packet_pixel_counter), 0);
    chk("rstmid_ovr", 32'(bus.island_overrun), 0);
    #2;
    reset_n = 1'b1;
    pe_cnt = 0;
    for (int x = 661; x <= 700; x++) begin
      step(x, 30);
      chk($sformatf("rstmid_after_mode@%0d", x), 32'(bus.mode), 0);
      pe_cnt += int'(bus.packet_enable);
    end
    chk("rstmid_after_pe", 32'(pe_cnt), 0);
    for (int x = 640; x <= 660; x++) begin
      step(x, 31);
      if (x == 644) chk("restart_ctl", 32'(bus.ctl), 5);
      if (x == 652) chk("restart_lead", 32'(bus.mode), 4);
      if (x == 653) chk("restart_pe", 32'(bus.packet_enable), 1);
      if (x == 660) chk("restart_ppc", 32'(bus.packet_pixel_counter), 6);
    end

    // Jump out of the island preamble must not produce a partial guard band
    for (int x = 640; x <= 647; x++) step(x, 40);
    chk("resync_pre_ctl", 32'(bus.ctl), 5);
    for (int x = 652; x <= 654; x++) begin
      step(x, 40);
      chk($sformatf("resync_mode@%0d", x), 32'(bus.mode), 0);
      chk($sformatf("resync_ctl@%0d", x), 32'(bus.ctl), 0);
      chk($sformatf("resync_pe@%0d", x), 32'(bus.packet_enable), 0);
    end

    // 700-wide frame: no room for any island
    bad_cnt = 0; pe_cnt = 0; m698 = -1; c690 = -1;
    for (int y = 0; y < 525; y++) begin
      for (int x = 630; x < 700; x++) begin
        step7(x, y);
        if (bus7.mode == 3'd3 || bus7.mode == 3'd4 || bus7.ctl == 4'b0101) bad_cnt++;
        pe_cnt += int'(bus7.packet_enable);
        if (y == 10 && x == 698) m698 = int'(bus7.mode);
        if (y == 10 && x == 690) c690 = int'(bus7.ctl);
      end
    end
    chk("fw700_island_states", 32'(bad_cnt), 0);
    chk("fw700_pe", 32'(pe_cnt), 0);
    chk("fw700_guard", 32'(m698), 2);
    chk("fw700_pre", 32'(c690), 1);

`ifdef HDMI_SCHED_DVI_FALLBACK_EN
    bus.dvi_mode = 1'b1;
    bad_cnt = 0; pe_cnt = 0; vfe_cnt = 0;
    for (int y = 478; y < 482; y++) begin
      for (int x = 0; x < 800; x++) begin
        step(x, (y == 481) ? 524 : y);
        if (bus.mode > 3'd1 || bus.ctl != 4'b0000) bad_cnt++;
        pe_cnt  += int'(bus.packet_enable);
        vfe_cnt += int'(bus.video_field_end);
      end
    end
    for (int x = 0; x < 800; x++) begin
      step(x, 10);
      if (bus.mode > 3'd1 || bus.ctl != 4'b0000) bad_cnt++;
      pe_cnt += int'(bus.packet_enable);
    end
    chk("dvi_states", 32'(bad_cnt), 0);
    chk("dvi_pe", 32'(pe_cnt), 0);
    chk("dvi_vfe", 32'(vfe_cnt), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
